tone_voice_scheduler: RTL and testbench
=======================================

# tone_voice_scheduler

Time-multiplexes one shared combinational sine/frequency ROM among `VOICES` independent tone voices. On each audio sample tick it visits every voice in turn, using one ROM access per voice. For each voice it drives the ROM with that voice's phase and note id, accumulates the returned level, and advances the voice's 16-bit phase by the ROM's `freq` value. After the last voice it presents the summed sample with a one-cycle valid strobe. It sits between the note/keyboard logic and the audio output (PWM/DAC) stage.

## Interface
Parameters:
- `VOICES`, 4 — number of voices; power of two, 2..8.
- `BITS`, 6 — ROM level width.
- `SW`, `BITS+$clog2(VOICES)` — sample width; derived, not overridden.

Ports:
- `clk_in` input 1 — system clock; the only clock.
- `rst_n` input 1 — reset, asynchronous assert, active-low.
- `sample_tick` input 1 — single-cycle sample request.
- `voice_en` input VOICES — per-voice enable.
- `voice_freq_id` input 5*VOICES — note id per voice; voice v occupies bits [5v+4:5v]; id 31 means silent.
- `rom_index` output 11 — ROM phase index, registered.
- `rom_freq_id` output 5 — ROM note id, registered.
- `rom_level` input BITS — ROM level, valid in the same cycle as the address.
- `rom_freq` input 16 — ROM phase increment.
- `sample` output SW — mixed sample, held between frames.
- `sample_valid` output 1 — one-cycle strobe marking a new `sample`.
- `busy` output 1 — a frame is in progress.
- `overrun` output 1 — one-cycle pulse when a tick is dropped.

## Operation
- **States.** The FSM has two states, IDLE and SCAN. A voice counter `v` counts 0..VOICES-1.
- **IDLE.**
  - When `sample_tick` is sampled high, snapshot `voice_en` and `voice_freq_id` into shadow registers.
  - Clear the accumulator, set `v`=0 and enter SCAN.
  - Load `rom_index`/`rom_freq_id` for voice 0.
- **SCAN, each cycle for voice v.**
  - The ROM settles combinationally from the registered address.
  - At the closing edge, if voice v is enabled: `acc += rom_level` and `phase[v] += rom_freq` (mod 2^16).
  - Then either load the address of voice v+1 and increment `v`, or, if v=VOICES-1, write `sample <= acc + rom_level` (with enable gating), pulse `sample_valid` and return to IDLE.
- **Address mapping.**
  - Enabled voice: `rom_index = {1'b0, phase[v][15:6]}`, giving 0..1023; `rom_freq_id` = the shadow id.
  - Disabled voice: `rom_index` = 0 and `rom_freq_id` = 31. It contributes 0 and its phase is forced to 0.
- **Note changes.** A changed `voice_freq_id` on an enabled voice keeps its phase, so retuning is glitch-free.
- **Widths.** `acc` and `sample` are SW bits wide. By construction the sum cannot overflow, so no saturation is needed.
- **Tick during SCAN.** The tick is ignored and `overrun` pulses in the following cycle. The frame is unaffected.
- **Tick in the same cycle as `sample_valid`.** The FSM is already in IDLE, so the tick is accepted.
- **Reset.**
  - All phases are 0, the FSM is in IDLE and `v`=0.
  - `rom_index`=0, `rom_freq_id`=31, `sample`=0.
  - `sample_valid`, `busy` and `overrun` are all 0.
  - Reset mid-frame aborts the frame; no `sample_valid` is produced.

## Timing
- Tick sampled high at the end of cycle 0. SCAN runs for voice v in cycle v+1.
- `busy` is high in cycles 1..VOICES.
- `sample_valid` is high in cycle VOICES+1 (cycle 5 for VOICES=4).
- Minimum tick spacing is VOICES+1 cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.
- `rom_level`/`rom_freq` are consumed in the same cycle they are produced. The ROM path must meet a single clock cycle.

## Test plan
- **Single voice.** Voice 0 only enabled at id 24 (freq 7268); ticks spaced 20 cycles.
  - Tick 1: `sample` 0.
  - Tick 2: index 113, `sample` 30.
  - Tick 3: index 227, `sample` 47.
  - Tick 11: phase wraps to 7144, index 111, `sample` 30.
- **Four voices at id 0 (freq 1817), VOICES=4.**
  - Tick 1: `sample` 0.
  - Tick 2: each index 28 (level 8), `sample` 32.
  - `sample_valid` exactly 5 cycles after the tick; `busy` high for 4 cycles.
- **Silent and disabled voices.**
  - All voices enabled at id 31: `sample` stays 0 and `rom_index` stays 0 for 10 ticks.
  - Then disable voice 0 and re-enable it: its phase restarts at 0.
- **Overrun.** Assert `sample_tick` at cycle 2 of a frame.
  - `overrun` pulses in cycle 3.
  - Exactly one `sample_valid` is produced and the sample value is unchanged.
  - A tick coincident with `sample_valid` starts a new frame.
- **Reset.** Drop `rst_n` in cycle 2 of a frame.
  - All outputs go to reset values immediately.
  - No `sample_valid`.
  - After release, the first frame yields `sample` 0.

Source files
------------

// File: rtl/tone_voice_scheduler.sv
// Shares one combinational sine/frequency ROM among VOICES tone voices, one ROM
// access per voice per sample tick, and sums the voice levels into one sample.
module tone_voice_scheduler #(
  parameter int VOICES = 4,
  parameter int BITS   = 6,
  localparam int SW    = BITS + $clog2(VOICES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [VOICES-1:0]     voice_en,
  input  logic [5*VOICES-1:0]   voice_freq_id,
  output logic [10:0]           rom_index,
  output logic [4:0]            rom_freq_id,
  input  logic [BITS-1:0]       rom_level,
  input  logic [15:0]           rom_freq,
  output logic [SW-1:0]         sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int VW = $clog2(VOICES);
  localparam logic [4:0] SILENT_ID = 5'd31;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state;
  logic [VW-1:0]        v;
  logic [15:0]          phase [VOICES];
  logic [VOICES-1:0]    en_sh;
  logic [5*VOICES-1:0]  id_sh;
  logic [SW-1:0]        acc;

  logic [VW-1:0]        vn;
  logic                 nxt_en;
  logic [4:0]           nxt_id;
  logic [15:0]          nxt_phase;
  logic [10:0]          nxt_index;
  logic [4:0]           nxt_fid;
  logic [SW-1:0]        lvl_add;

  // Address of the voice that will be scanned next cycle. From IDLE that is
  // voice 0, taken straight from the inputs being snapshotted on the same edge.
  always_comb begin
    vn        = v + 1'b1;
    nxt_en    = 1'b0;
    nxt_id    = SILENT_ID;
    nxt_phase = '0;
    if (state == IDLE) begin
      nxt_en    = voice_en[0];
      nxt_id    = voice_freq_id[4:0];
      nxt_phase = phase[0];
    end else begin
      nxt_en    = en_sh[vn];
      nxt_id    = id_sh[5*vn +: 5];
      nxt_phase = phase[vn];
    end
    nxt_index = nxt_en ? {1'b0, nxt_phase[15:6]} : '0;
    nxt_fid   = nxt_en ? nxt_id : SILENT_ID;
    lvl_add   = en_sh[v] ? {{(SW-BITS){1'b0}}, rom_level} : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      v            <= '0;
      en_sh        <= '0;
      id_sh        <= '1;
      acc          <= '0;
      for (int unsigned i = 0; i < VOICES; i++) phase[i] <= '0;
      rom_index    <= '0;
      rom_freq_id  <= SILENT_ID;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            en_sh       <= voice_en;
            id_sh       <= voice_freq_id;
            acc         <= '0;
            v           <= '0;
            rom_index   <= nxt_index;
            rom_freq_id <= nxt_fid;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (sample_tick) overrun <= 1'b1;
          // Disabled voices are held at phase 0 so they restart cleanly.
          phase[v] <= en_sh[v] ? phase[v] + rom_freq : '0;
          if (v == VW'(VOICES - 1)) begin
            sample       <= acc + lvl_add;
            sample_valid <= 1'b1;
            busy         <= 1'b0;
            v            <= '0;
            rom_index    <= '0;
            rom_freq_id  <= SILENT_ID;
            state        <= IDLE;
          end else begin
            acc         <= acc + lvl_add;
            v           <= vn;
            rom_index   <= nxt_index;
            rom_freq_id <= nxt_fid;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Scoreboard bench for tone_voice_scheduler: directed ticks push the expected
// voice-0 ROM index and mixed sample; a monitor checks each sample_valid.
module tb_tone_voice_scheduler;

  localparam int VOICES = 4;
  localparam int BITS   = 6;
  localparam int SW     = BITS + $clog2(VOICES);

  logic                 clk_in = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 sample_tick = 1'b0;
  logic [VOICES-1:0]    voice_en = '0;
  logic [5*VOICES-1:0]  voice_freq_id = '1;
  logic [10:0]          rom_index;
  logic [4:0]           rom_freq_id;
  logic [BITS-1:0]      rom_level;
  logic [15:0]          rom_freq;
  logic [SW-1:0]        sample;
  logic                 sample_valid;
  logic                 busy;
  logic                 overrun;

  tone_voice_scheduler #(.VOICES(VOICES), .BITS(BITS)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .voice_en      (voice_en),
    .voice_freq_id (voice_freq_id),
    .rom_index     (rom_index),
    .rom_freq_id   (rom_freq_id),
    .rom_level     (rom_level),
    .rom_freq      (rom_freq),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Stub ROM: a few fixed points for the directed cases, coarse ramp elsewhere.
  always_comb begin
    rom_level = {3'b000, 3'b000};
    rom_freq  = 16'd0;
    if (rom_freq_id != 5'd31) begin
      case (rom_index)
        11'd28:  rom_level = 6'd8;
        11'd111: rom_level = 6'd30;
        11'd113: rom_level = 6'd30;
        11'd227: rom_level = 6'd47;
        default: rom_level = rom_index[9:4];
      endcase
      case (rom_freq_id)
        5'd0:    rom_freq = 16'd1817;
        5'd24:   rom_freq = 16'd7268;
        default: rom_freq = 16'd1000 + 16'(rom_freq_id);
      endcase
    end
  end

  typedef struct {int idx; int smp;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor
  int tick_cyc = 0;
  int busy_cnt = 0;
  int idx0 = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (sample_valid) begin
        chk("valid_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sample", int'(sample), e.smp);
          chk("voice0_index", idx0, e.idx);
          chk("tick_to_valid", cyc - tick_cyc, VOICES + 1);
          chk("busy_cycles", busy_cnt, VOICES);
        end
      end
      if (busy && !prev_busy) begin
        busy_cnt = 1;
        idx0     = int'(rom_index);
      end else if (busy) begin
        busy_cnt++;
      end
      if (sample_tick && !busy) tick_cyc = cyc;
      prev_busy = busy;
    end
  end

  task automatic push(input int idx, input int smp);
    exp_t e;
    e.idx = idx;
    e.smp = smp;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int idx, input int smp, input int gap);
    @(posedge clk_in); #1;
    sample_tick = 1'b1;
    push(idx, smp);
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    repeat (gap) @(posedge clk_in);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_in);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_index"}, int'(rom_index), 0);
    chk({tag, "_rom_freq_id"}, int'(rom_freq_id), 31);
    chk({tag, "_sample"}, int'(sample), 0);
    chk({tag, "_valid"}, int'(sample_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  int sv_idx [11] = '{0, 113, 227, 340, 454, 567, 681, 794, 908, 1022, 111};
  int sv_smp [11] = '{0, 30, 47, 21, 28, 35, 42, 49, 56, 63, 30};

  initial begin
    // Single voice at id 24, ticks 20 cycles apart, phase wraps by tick 11
    do_reset();
    voice_en      = 4'b0001;
    voice_freq_id = {5'd31, 5'd31, 5'd31, 5'd24};
    for (int i = 0; i < 11; i++) tick(sv_idx[i], sv_smp[i], 18);
    drain();

    // Four voices at id 0
    do_reset();
    voice_en      = 4'b1111;
    voice_freq_id = {5'd0, 5'd0, 5'd0, 5'd0};
    tick(0, 0, 10);
    tick(28, 32, 10);
    drain();

    // All voices enabled but silent
    do_reset();
    voice_freq_id = {5'd31, 5'd31, 5'd31, 5'd31};
    for (int i = 0; i < 10; i++) tick(0, 0, 6);
    drain();

    // Disable then re-enable voice 0: phase restarts at 0
    do_reset();
    voice_en      = 4'b0001;
    voice_freq_id = {5'd31, 5'd31, 5'd31, 5'd0};
    tick(0, 0, 8);
    tick(28, 8, 8);
    tick(56, 3, 8);
    voice_en = 4'b0000;
    tick(0, 0, 8);
    voice_en = 4'b0001;
    tick(0, 0, 8);
    tick(28, 8, 8);
    drain();

    // Overrun: tick in cycle 2 dropped, tick coincident with valid accepted
    do_reset();
    voice_en      = 4'b0001;
    voice_freq_id = {5'd31, 5'd31, 5'd31, 5'd0};
    tick(0, 0, 8);
    @(posedge clk_in); #1;
    sample_tick = 1'b1;
    push(28, 8);
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    @(posedge clk_in); #1;
    sample_tick = 1'b1;
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    @(negedge clk_in);
    chk("overrun_pulse", int'(overrun), 1);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("overrun_clear", int'(overrun), 0);
    @(posedge clk_in); #1;
    sample_tick = 1'b1;
    push(56, 3);
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    repeat (10) @(posedge clk_in);
    drain();

    // Reset mid-frame aborts it; next frame starts from phase 0
    do_reset();
    voice_en      = 4'b1111;
    voice_freq_id = {5'd0, 5'd0, 5'd0, 5'd0};
    tick(0, 0, 8);
    tick(28, 32, 8);
    drain();
    @(posedge clk_in); #1;
    sample_tick = 1'b1;
    push(56, 12);
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    @(posedge clk_in); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("midframe");
    void'(exp_q.pop_back());
    repeat (8) @(posedge clk_in);
    #1 rst_n = 1'b1;
    tick(0, 0, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
